// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_stall_ctrl_pkg;

  // Controller FSM encoding
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Instruction word loaded into IF/ID or ID/EX on a flush or bubble
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Width of the drain watchdog timer; covers DRAIN_MAX up to 255
  localparam int TIMER_W = 8;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-flag inputs and pipeline-register controls of the stall controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; controls are plain levels sampled by the pipeline registers.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             data_hazard;
  logic             control_hazard;
  logic             redirect_valid;
  logic             cnt_clr;
  logic             pc_we;
  logic             pc_sel_redirect;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             drain_active;
  logic             ctrl_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Hazard detector / PC side: drives flags, observes controls
  modport master (
    output data_hazard, control_hazard, redirect_valid, cnt_clr,
    input  pc_we, pc_sel_redirect, ifid_we, ifid_flush, idex_bubble,
    input  drain_active, ctrl_error, stall_cnt, flush_cnt
  );

  // Stall controller side
  modport slave (
    input  data_hazard, control_hazard, redirect_valid, cnt_clr,
    output pc_we, pc_sel_redirect, ifid_we, ifid_flush, idex_bubble,
    output drain_active, ctrl_error, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates on the edge after inc/clr; clr wins over inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module pipeline_stall_ctrl_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Clear has priority; otherwise count up until all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Turns ID-stage hazard flags into PC / IF-ID / ID-EX controls; sequences CALL/RET drains.
// Latency: controls are combinational from state and flags; state, timer, counters register.
// Backpressure: data hazards freeze PC and IF/ID; control hazards drain until redirect or watchdog.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DRAIN_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_stall_ctrl_if.slave ctrl
);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               error_q;
  logic               timeout;
  logic [CNT_W-1:0]   stall_q;
  logic [CNT_W-1:0]   flush_q;

  // Watchdog hits on the last permitted drain cycle without a redirect
  assign timeout = (state == ST_DRAIN) && !ctrl.redirect_valid &&
                   (timer == TIMER_W'(DRAIN_MAX - 1));

  // Pipeline controls decoded from current state and hazard flags
  always_comb begin
    ctrl.pc_we           = 1'b1;
    ctrl.pc_sel_redirect = 1'b0;
    ctrl.ifid_we         = 1'b1;
    ctrl.ifid_flush      = 1'b0;
    ctrl.idex_bubble     = 1'b0;
    ctrl.drain_active    = 1'b0;
    if (state == ST_RUN) begin
      if (ctrl.data_hazard) begin
        // Freeze fetch and ID, inject a bubble into EX
        ctrl.pc_we       = 1'b0;
        ctrl.ifid_we     = 1'b0;
        ctrl.idex_bubble = 1'b1;
      end else if (ctrl.control_hazard) begin
        // CALL/RET moves on; the wrong-path fetch behind it is squashed
        ctrl.pc_we      = 1'b0;
        ctrl.ifid_flush = 1'b1;
      end
    end else begin
      // Only NOPs reach ID while the CALL/RET is downstream
      ctrl.pc_we           = ctrl.redirect_valid;
      ctrl.pc_sel_redirect = ctrl.redirect_valid;
      ctrl.ifid_flush      = 1'b1;
      ctrl.drain_active    = 1'b1;
    end
  end

  // FSM and drain timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      timer <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!ctrl.data_hazard && ctrl.control_hazard) begin
            state <= ST_DRAIN;
            timer <= '0;
          end
        end
        ST_DRAIN: begin
          if (ctrl.redirect_valid || timeout) begin
            state <= ST_RUN;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
          timer <= '0;
        end
      endcase
    end
  end

  // Sticky watchdog error; clear wins over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (ctrl.cnt_clr) begin
      error_q <= 1'b0;
    end else if (timeout) begin
      error_q <= 1'b1;
    end
  end

  pipeline_stall_ctrl_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.idex_bubble),
    .clr   (ctrl.cnt_clr),
    .count (stall_q)
  );

  pipeline_stall_ctrl_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.ifid_flush),
    .clr   (ctrl.cnt_clr),
    .count (flush_q)
  );

  assign ctrl.ctrl_error = error_q;
  assign ctrl.stall_cnt  = stall_q;
  assign ctrl.flush_cnt  = flush_q;

endmodule
